// File: rtl/ctrl_pipe_pkg.sv
// Shared encodings for the pipelined MIPS control unit: opcode/funct values,
// control-field codes and the control word carried through E/M/W.
package ctrl_pipe_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MTHI  = 6'h11;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MTLO  = 6'h13;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_DIV   = 6'h1a;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;

    localparam logic [1:0] NPC_PC4  = 2'b00;
    localparam logic [1:0] NPC_J    = 2'b01;
    localparam logic [1:0] NPC_BEQ  = 2'b10;
    localparam logic [1:0] NPC_JR   = 2'b11;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_OR   = 3'b010;
    localparam logic [2:0] ALU_LUI  = 3'b101;

    localparam logic [2:0] MD_NONE  = 3'b000;
    localparam logic [2:0] MD_MULT  = 3'b001;
    localparam logic [2:0] MD_DIV   = 3'b010;
    localparam logic [2:0] MD_MTHI  = 3'b011;
    localparam logic [2:0] MD_MTLO  = 3'b100;
    localparam logic [2:0] MD_MFHI  = 3'b101;
    localparam logic [2:0] MD_MFLO  = 3'b110;

    localparam logic [1:0] MTR_ALU  = 2'b00;
    localparam logic [1:0] MTR_DM   = 2'b01;
    localparam logic [1:0] MTR_PC8  = 2'b10;
    localparam logic [1:0] MTR_HILO = 2'b11;

    typedef struct packed {
        logic [4:0] a3;
        logic [1:0] tnew;
        logic [2:0] aluctrl;
        logic       alusrc;
        logic [2:0] mdop;
        logic       memwrite;
        logic       regwrite;
        logic [1:0] memtoreg;
    } ctrl_word_t;

    localparam ctrl_word_t CW_BUBBLE = '0;

    function automatic logic [1:0] sat_dec(input logic [1:0] t);
        return (t == 2'd0) ? 2'd0 : t - 2'd1;
    endfunction

    // A control word moving one stage down loses one cycle of Tnew.
    function automatic ctrl_word_t advance(input ctrl_word_t cw);
        ctrl_word_t nxt;
        nxt      = cw;
        nxt.tnew = sat_dec(cw.tnew);
        return nxt;
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// D-stage decoder: turns the instruction fields into the control word that
// travels down the pipe, plus the operand-use times needed for hazard checks.
module ctrl_decode
    import ctrl_pipe_pkg::*;
(
    input  logic [5:0]  op,
    input  logic [5:0]  fn,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    output ctrl_word_t  cw,
    output logic        extop,
    output logic [1:0]  npcop,
    output logic        use_rs,
    output logic [1:0]  tuse_rs,
    output logic        use_rt,
    output logic [1:0]  tuse_rt
);

    always_comb begin
        cw      = CW_BUBBLE;
        extop   = 1'b0;
        npcop   = NPC_PC4;
        use_rs  = 1'b0;
        tuse_rs = 2'd0;
        use_rt  = 1'b0;
        tuse_rt = 2'd0;
        case (op)
            OP_RTYPE: begin
                case (fn)
                    FN_ADD, FN_SUB: begin
                        cw.a3       = rd;
                        cw.tnew     = 2'd1;
                        cw.aluctrl  = (fn == FN_SUB) ? ALU_SUB : ALU_ADD;
                        cw.regwrite = 1'b1;
                        use_rs      = 1'b1;
                        tuse_rs     = 2'd1;
                        use_rt      = 1'b1;
                        tuse_rt     = 2'd1;
                    end
                    FN_JR: begin
                        npcop  = NPC_JR;
                        use_rs = 1'b1;
                    end
                    FN_MULT, FN_DIV: begin
                        cw.mdop = (fn == FN_DIV) ? MD_DIV : MD_MULT;
                        use_rs  = 1'b1;
                        tuse_rs = 2'd1;
                        use_rt  = 1'b1;
                        tuse_rt = 2'd1;
                    end
                    FN_MFHI, FN_MFLO: begin
                        cw.a3       = rd;
                        cw.tnew     = 2'd1;
                        cw.mdop     = (fn == FN_MFHI) ? MD_MFHI : MD_MFLO;
                        cw.regwrite = 1'b1;
                        cw.memtoreg = MTR_HILO;
                    end
                    FN_MTHI, FN_MTLO: begin
                        cw.mdop = (fn == FN_MTHI) ? MD_MTHI : MD_MTLO;
                        use_rs  = 1'b1;
                        tuse_rs = 2'd1;
                    end
                    default: ;
                endcase
            end
            OP_ORI: begin
                cw.a3       = rt;
                cw.tnew     = 2'd1;
                cw.aluctrl  = ALU_OR;
                cw.alusrc   = 1'b1;
                cw.regwrite = 1'b1;
                use_rs      = 1'b1;
                tuse_rs     = 2'd1;
            end
            OP_LUI: begin
                cw.a3       = rt;
                cw.tnew     = 2'd1;
                cw.aluctrl  = ALU_LUI;
                cw.alusrc   = 1'b1;
                cw.regwrite = 1'b1;
            end
            OP_LW: begin
                cw.a3       = rt;
                cw.tnew     = 2'd2;
                cw.alusrc   = 1'b1;
                cw.regwrite = 1'b1;
                cw.memtoreg = MTR_DM;
                extop       = 1'b1;
                use_rs      = 1'b1;
                tuse_rs     = 2'd1;
            end
            OP_SW: begin
                cw.alusrc   = 1'b1;
                cw.memwrite = 1'b1;
                extop       = 1'b1;
                use_rs      = 1'b1;
                tuse_rs     = 2'd1;
                use_rt      = 1'b1;
                tuse_rt     = 2'd2;
            end
            OP_BEQ: begin
                npcop  = NPC_BEQ;
                use_rs = 1'b1;
                use_rt = 1'b1;
            end
            OP_J: begin
                npcop = NPC_J;
            end
            OP_JAL: begin
                cw.a3       = 5'd31;
                cw.regwrite = 1'b1;
                cw.memtoreg = MTR_PC8;
                npcop       = NPC_J;
            end
            default: ;
        endcase
        // Writing $0 is architecturally a no-op, so never raise the GRF enable for it.
        cw.regwrite = cw.regwrite & (cw.a3 != 5'd0);
    end

endmodule

// File: rtl/ctrl_pipe.sv
// Pipelined control unit: decodes in D, carries the control word through
// E/M/W, stalls on Tuse/Tnew RAW hazards and while the mult/div unit is busy.
module ctrl_pipe
    import ctrl_pipe_pkg::*;
#(
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10,
    parameter int CNT_W    = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] D_instr,
    output logic        stall,
    output logic        D_EXTop,
    output logic [1:0]  D_NPCop,
    output logic [2:0]  E_ALUctrl,
    output logic        E_ALUsrc,
    output logic [2:0]  E_MDop,
    output logic        E_MDstart,
    output logic        md_busy,
    output logic [4:0]  E_A3,
    output logic [4:0]  M_A3,
    output logic [4:0]  W_A3,
    output logic [1:0]  E_Tnew,
    output logic [1:0]  M_Tnew,
    output logic        M_MemWrite,
    output logic        W_RegWrite,
    output logic [1:0]  W_MemtoReg
);

    // The start cycle itself counts as busy, so the counter covers the remainder.
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYC - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYC - 1);

    ctrl_word_t       d_cw, e_cw, m_cw, w_cw;
    logic             use_rs, use_rt;
    logic [1:0]       tuse_rs, tuse_rt;
    logic [4:0]       rs, rt;
    logic             raw_rs, raw_rt, md_stall;
    logic [CNT_W-1:0] cnt;
    logic             unused_bits;

    assign rs = D_instr[25:21];
    assign rt = D_instr[20:16];

    ctrl_decode u_decode (
        .op      (D_instr[31:26]),
        .fn      (D_instr[5:0]),
        .rt      (rt),
        .rd      (D_instr[15:11]),
        .cw      (d_cw),
        .extop   (D_EXTop),
        .npcop   (D_NPCop),
        .use_rs  (use_rs),
        .tuse_rs (tuse_rs),
        .use_rt  (use_rt),
        .tuse_rt (tuse_rt)
    );

    assign raw_rs = use_rs && (rs != 5'd0) &&
                    (((e_cw.a3 == rs) && (e_cw.tnew > tuse_rs)) ||
                     ((m_cw.a3 == rs) && (m_cw.tnew > tuse_rs)));
    assign raw_rt = use_rt && (rt != 5'd0) &&
                    (((e_cw.a3 == rt) && (e_cw.tnew > tuse_rt)) ||
                     ((m_cw.a3 == rt) && (m_cw.tnew > tuse_rt)));

    assign md_stall = (d_cw.mdop != MD_NONE) && md_busy;
    assign stall    = raw_rs || raw_rt || md_stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            e_cw <= CW_BUBBLE;
            m_cw <= CW_BUBBLE;
            w_cw <= CW_BUBBLE;
        end else begin
            e_cw <= stall ? CW_BUBBLE : d_cw;
            m_cw <= advance(e_cw);
            w_cw <= advance(m_cw);
        end
    end

    assign E_MDstart = (e_cw.mdop == MD_MULT) || (e_cw.mdop == MD_DIV);
    assign md_busy   = E_MDstart || (cnt != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (E_MDstart) begin
            cnt <= (e_cw.mdop == MD_DIV) ? DIV_LOAD : MULT_LOAD;
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign E_ALUctrl  = e_cw.aluctrl;
    assign E_ALUsrc   = e_cw.alusrc;
    assign E_MDop     = e_cw.mdop;
    assign E_A3       = e_cw.a3;
    assign E_Tnew     = e_cw.tnew;
    assign M_A3       = m_cw.a3;
    assign M_Tnew     = m_cw.tnew;
    assign M_MemWrite = m_cw.memwrite;
    assign W_A3       = w_cw.a3;
    assign W_RegWrite = w_cw.regwrite;
    assign W_MemtoReg = w_cw.memtoreg;

    assign unused_bits = ^{D_instr[10:6], w_cw.tnew, w_cw.aluctrl, w_cw.alusrc,
                           w_cw.mdop, w_cw.memwrite};

endmodule

// File: tb/tb_ctrl_pipe.sv
// Scoreboard bench for ctrl_pipe: a timeline model of in-flight instructions
// predicts every cycle's outputs; a negedge monitor compares them.
module tb_ctrl_pipe;

    localparam int MULT_CYC = 5;
    localparam int DIV_CYC  = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] D_instr = 32'h0;
    logic        stall, D_EXTop, E_ALUsrc, E_MDstart, md_busy;
    logic        M_MemWrite, W_RegWrite;
    logic [1:0]  D_NPCop, E_Tnew, M_Tnew, W_MemtoReg;
    logic [2:0]  E_ALUctrl, E_MDop;
    logic [4:0]  E_A3, M_A3, W_A3;

    ctrl_pipe #(.MULT_CYC(MULT_CYC), .DIV_CYC(DIV_CYC), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .D_instr(D_instr), .stall(stall),
        .D_EXTop(D_EXTop), .D_NPCop(D_NPCop), .E_ALUctrl(E_ALUctrl),
        .E_ALUsrc(E_ALUsrc), .E_MDop(E_MDop), .E_MDstart(E_MDstart),
        .md_busy(md_busy), .E_A3(E_A3), .M_A3(M_A3), .W_A3(W_A3),
        .E_Tnew(E_Tnew), .M_Tnew(M_Tnew), .M_MemWrite(M_MemWrite),
        .W_RegWrite(W_RegWrite), .W_MemtoReg(W_MemtoReg)
    );

    always #5 clk = ~clk;

    typedef enum int {
        I_ADD, I_SUB, I_ORI, I_LW, I_SW, I_BEQ, I_LUI, I_JAL, I_JR, I_J,
        I_MULT, I_DIV, I_MFHI, I_MFLO, I_MTHI, I_MTLO, I_BAD, I_NOP
    } op_e;

    typedef struct {
        op_e op;
        int  rs, rt, rd;
        bit  rst;
    } ins_t;

    typedef struct {
        int a3, tnew0, alu, alusrc, md, mw, rw, mtr, ext, npc;
        int rs, rt, tuse_rs, tuse_rt;
        bit use_rs, use_rt;
    } info_t;

    typedef struct {
        info_t inf;
        int    entry;
    } flight_t;

    typedef struct {
        int cyc, stall, ext, npc, e_alu, e_alusrc, e_md, e_start, busy;
        int e_a3, m_a3, w_a3, e_tnew, m_tnew, m_mw, w_rw, w_mtr;
    } exp_t;

    flight_t pipe[$];
    exp_t    expq[$];
    int      cyc = 0;
    int      md_end = -1;
    bit      model_valid = 1'b0;
    int      total = 0;
    int      bad = 0;

    function automatic ins_t mk(op_e op, int rs, int rt, int rd, bit rst);
        ins_t i;
        i.op = op; i.rs = rs; i.rt = rt; i.rd = rd; i.rst = rst;
        return i;
    endfunction

    function automatic logic [31:0] encode(ins_t i);
        logic [4:0] s, t, d;
        s = 5'(i.rs); t = 5'(i.rt); d = 5'(i.rd);
        case (i.op)
            I_ADD:  return {6'h00, s, t, d, 5'h0, 6'h20};
            I_SUB:  return {6'h00, s, t, d, 5'h0, 6'h22};
            I_JR:   return {6'h00, s, t, d, 5'h0, 6'h08};
            I_MULT: return {6'h00, s, t, d, 5'h0, 6'h18};
            I_DIV:  return {6'h00, s, t, d, 5'h0, 6'h1a};
            I_MFHI: return {6'h00, s, t, d, 5'h0, 6'h10};
            I_MFLO: return {6'h00, s, t, d, 5'h0, 6'h12};
            I_MTHI: return {6'h00, s, t, d, 5'h0, 6'h11};
            I_MTLO: return {6'h00, s, t, d, 5'h0, 6'h13};
            I_ORI:  return {6'h0d, s, t, 16'h0010};
            I_LUI:  return {6'h0f, s, t, 16'h0010};
            I_LW:   return {6'h23, s, t, 16'h0010};
            I_SW:   return {6'h2b, s, t, 16'h0010};
            I_BEQ:  return {6'h04, s, t, 16'h0010};
            I_J:    return {6'h02, 26'h0000040};
            I_JAL:  return {6'h03, 26'h0000040};
            I_BAD:  return {6'h3f, s, t, d, 5'h0, 6'h20};
            default: return 32'h0;
        endcase
    endfunction

    // What each instruction means to the pipe, straight from the ISA rules.
    function automatic info_t describe(ins_t i);
        info_t f;
        f = '{default: 0};
        f.rs = i.rs; f.rt = i.rt;
        case (i.op)
            I_ADD, I_SUB: begin
                f.a3 = i.rd; f.tnew0 = 1; f.alu = (i.op == I_SUB) ? 1 : 0;
                f.rw = (i.rd != 0) ? 1 : 0;
                f.use_rs = 1; f.tuse_rs = 1; f.use_rt = 1; f.tuse_rt = 1;
            end
            I_ORI: begin
                f.a3 = i.rt; f.tnew0 = 1; f.alu = 2; f.alusrc = 1;
                f.rw = (i.rt != 0) ? 1 : 0; f.use_rs = 1; f.tuse_rs = 1;
            end
            I_LUI: begin
                f.a3 = i.rt; f.tnew0 = 1; f.alu = 5; f.alusrc = 1;
                f.rw = (i.rt != 0) ? 1 : 0;
            end
            I_LW: begin
                f.a3 = i.rt; f.tnew0 = 2; f.alusrc = 1; f.mtr = 1; f.ext = 1;
                f.rw = (i.rt != 0) ? 1 : 0; f.use_rs = 1; f.tuse_rs = 1;
            end
            I_SW: begin
                f.alusrc = 1; f.mw = 1; f.ext = 1;
                f.use_rs = 1; f.tuse_rs = 1; f.use_rt = 1; f.tuse_rt = 2;
            end
            I_BEQ:  begin f.npc = 2; f.use_rs = 1; f.use_rt = 1; end
            I_JAL:  begin f.a3 = 31; f.rw = 1; f.mtr = 2; f.npc = 1; end
            I_J:    f.npc = 1;
            I_JR:   begin f.npc = 3; f.use_rs = 1; end
            I_MULT, I_DIV: begin
                f.md = (i.op == I_DIV) ? 2 : 1;
                f.use_rs = 1; f.tuse_rs = 1; f.use_rt = 1; f.tuse_rt = 1;
            end
            I_MFHI, I_MFLO: begin
                f.a3 = i.rd; f.tnew0 = 1; f.md = (i.op == I_MFHI) ? 5 : 6;
                f.mtr = 3; f.rw = (i.rd != 0) ? 1 : 0;
            end
            I_MTHI, I_MTLO: begin
                f.md = (i.op == I_MTHI) ? 3 : 4; f.use_rs = 1; f.tuse_rs = 1;
            end
            default: ;
        endcase
        return f;
    endfunction

    function automatic bit at_age(int age, output info_t s);
        s = '{default: 0};
        foreach (pipe[k]) begin
            if (cyc - pipe[k].entry == age) begin
                s = pipe[k].inf;
                return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    function automatic int tnew_now(info_t s, int age);
        return (s.tnew0 - age > 0) ? s.tnew0 - age : 0;
    endfunction

    function automatic bit model_busy();
        info_t s;
        if (at_age(0, s) && (s.md == 1 || s.md == 2)) return 1'b1;
        return cyc <= md_end;
    endfunction

    // A source waits while any producer one or two cycles ahead still needs more time than the reader can give.
    function automatic bit model_stall(info_t d);
        info_t s;
        bit st;
        st = 1'b0;
        for (int age = 0; age < 2; age++) begin
            if (at_age(age, s) && s.a3 != 0) begin
                if (d.use_rs && d.rs != 0 && s.a3 == d.rs && tnew_now(s, age) > d.tuse_rs) st = 1'b1;
                if (d.use_rt && d.rt != 0 && s.a3 == d.rt && tnew_now(s, age) > d.tuse_rt) st = 1'b1;
            end
        end
        if (d.md != 0 && model_busy()) st = 1'b1;
        return st;
    endfunction

    function automatic exp_t expect_now(info_t d, bit st);
        exp_t  e;
        info_t s;
        e = '{default: 0};
        e.cyc = cyc; e.stall = st; e.ext = d.ext; e.npc = d.npc; e.busy = model_busy();
        if (at_age(0, s)) begin
            e.e_alu = s.alu; e.e_alusrc = s.alusrc; e.e_md = s.md;
            e.e_start = (s.md == 1 || s.md == 2) ? 1 : 0;
            e.e_a3 = s.a3; e.e_tnew = tnew_now(s, 0);
        end
        if (at_age(1, s)) begin
            e.m_a3 = s.a3; e.m_tnew = tnew_now(s, 1); e.m_mw = s.mw;
        end
        if (at_age(2, s)) begin
            e.w_a3 = s.a3; e.w_rw = s.rw; e.w_mtr = s.mtr;
        end
        return e;
    endfunction

    function automatic void model_edge(info_t d, bit rst, bit st);
        info_t s;
        flight_t f;
        if (rst) begin
            pipe.delete();
            md_end = -1;
            model_valid = 1'b1;
        end else begin
            if (at_age(0, s) && (s.md == 1 || s.md == 2))
                md_end = cyc + ((s.md == 2) ? DIV_CYC : MULT_CYC) - 1;
            if (!st) begin
                f.inf = d; f.entry = cyc + 1;
                pipe.push_back(f);
            end
        end
        cyc++;
        while (pipe.size() > 0 && cyc - pipe[0].entry > 2) void'(pipe.pop_front());
    endfunction

    task automatic chk(string nm, int c, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("[TB] FAIL %s cyc=%0d got=%0d want=%0d", nm, c, act, exp);
        end
    endtask

    task automatic checkOutput(exp_t e);
        chk("stall",      e.cyc, int'(stall),      e.stall);
        chk("D_EXTop",    e.cyc, int'(D_EXTop),    e.ext);
        chk("D_NPCop",    e.cyc, int'(D_NPCop),    e.npc);
        chk("E_ALUctrl",  e.cyc, int'(E_ALUctrl),  e.e_alu);
        chk("E_ALUsrc",   e.cyc, int'(E_ALUsrc),   e.e_alusrc);
        chk("E_MDop",     e.cyc, int'(E_MDop),     e.e_md);
        chk("E_MDstart",  e.cyc, int'(E_MDstart),  e.e_start);
        chk("md_busy",    e.cyc, int'(md_busy),    e.busy);
        chk("E_A3",       e.cyc, int'(E_A3),       e.e_a3);
        chk("M_A3",       e.cyc, int'(M_A3),       e.m_a3);
        chk("W_A3",       e.cyc, int'(W_A3),       e.w_a3);
        chk("E_Tnew",     e.cyc, int'(E_Tnew),     e.e_tnew);
        chk("M_Tnew",     e.cyc, int'(M_Tnew),     e.m_tnew);
        chk("M_MemWrite", e.cyc, int'(M_MemWrite), e.m_mw);
        chk("W_RegWrite", e.cyc, int'(W_RegWrite), e.w_rw);
        chk("W_MemtoReg", e.cyc, int'(W_MemtoReg), e.w_mtr);
    endtask

    always @(negedge clk) begin
        if (expq.size() > 0) checkOutput(expq.pop_front());
    end

    // Holds the instruction in D for as long as the model says the pipe stalls it.
    task automatic applyStimulus(ins_t i);
        info_t d;
        bit    st;
        int    spins;
        d = describe(i);
        spins = 0;
        do begin
            D_instr = encode(i);
            reset   = i.rst;
            st = model_stall(d);
            if (model_valid) expq.push_back(expect_now(d, st));
            @(posedge clk);
            #1;
            model_edge(d, i.rst, st);
            spins++;
        end while (st && !i.rst && spins < 40);
        if (st && !i.rst) chk("stall_bound", cyc, spins, 0);
    endtask

    task automatic nops(int n);
        for (int k = 0; k < n; k++) applyStimulus(mk(I_NOP, 0, 0, 0, 1'b0));
    endtask

    initial begin
        op_e ops[17];
        ops = '{I_ADD, I_SUB, I_ORI, I_LW, I_SW, I_BEQ, I_LUI, I_JAL, I_JR, I_J,
                I_MULT, I_DIV, I_MFHI, I_MFLO, I_MTHI, I_MTLO, I_BAD};
        $display("[TB] ctrl_pipe scoreboard run starting");

        applyStimulus(mk(I_ADD, 1, 2, 3, 1'b1));
        applyStimulus(mk(I_ADD, 1, 2, 3, 1'b1));
        applyStimulus(mk(I_ADD, 1, 2, 3, 1'b0));
        nops(3);

        applyStimulus(mk(I_LW, 0, 5, 0, 1'b0));
        applyStimulus(mk(I_ADD, 5, 5, 6, 1'b0));
        nops(3);

        applyStimulus(mk(I_LW, 0, 5, 0, 1'b0));
        applyStimulus(mk(I_BEQ, 5, 0, 0, 1'b0));
        nops(3);
        applyStimulus(mk(I_ADD, 1, 2, 5, 1'b0));
        applyStimulus(mk(I_BEQ, 5, 0, 0, 1'b0));
        nops(3);

        applyStimulus(mk(I_MULT, 1, 2, 0, 1'b0));
        applyStimulus(mk(I_MFLO, 0, 0, 4, 1'b0));
        nops(4);

        applyStimulus(mk(I_DIV, 1, 2, 0, 1'b0));
        nops(2);
        applyStimulus(mk(I_NOP, 0, 0, 0, 1'b1));
        applyStimulus(mk(I_MULT, 1, 2, 0, 1'b0));
        nops(7);

        applyStimulus(mk(I_ADD, 1, 2, 0, 1'b0));
        applyStimulus(mk(I_ADD, 0, 0, 7, 1'b0));
        applyStimulus(mk(I_BAD, 1, 2, 3, 1'b0));
        applyStimulus(mk(I_JAL, 0, 0, 0, 1'b0));
        applyStimulus(mk(I_JR, 31, 0, 0, 1'b0));
        applyStimulus(mk(I_SW, 2, 31, 0, 1'b0));
        nops(3);

        for (int n = 0; n < 400; n++) begin
            applyStimulus(mk(ops[$urandom_range(0, 16)],
                             int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                             int'($urandom_range(0, 7)), ($urandom_range(0, 49) == 0)));
        end
        nops(3);

        chk("queue_drained", cyc, expq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog cyc=%0d got=running want=finished", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
